// File: rtl/add_sub_pipe_pkg.sv
// Shared definitions for the pipelined adder/subtractor: operation encodings
// also used by the ALU decoder.
package add_sub_pipe_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit adder slice. Also reports the carry into the slice
// MSB so the final stage can derive signed overflow.
module add_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout,
   output logic             c_msb
);

   logic [CHUNK:0] full;

   assign full  = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
   assign s     = full[CHUNK-1:0];
   assign cout  = full[CHUNK];
   // sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out of the XOR
   assign c_msb = a[CHUNK-1] ^ b[CHUNK-1] ^ s[CHUNK-1];

endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined two's-complement adder/subtractor. One CHUNK-bit slice is resolved
// per stage; upper operand slices ride along (skew) and finished lower result
// slices accumulate (deskew). The whole pipe advances as one on en.
module add_sub_pipe
   import add_sub_pipe_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf,
   output logic             zero
);

   localparam int STAGES = WIDTH / CHUNK;

   logic                          en;
   logic [STAGES:1]               vld_pipe;
   logic [STAGES-1:0][WIDTH-1:0]  a_q, b_q, r_q;
   logic [STAGES-1:0][WIDTH-1:0]  a_d, b_d, r_d;
   logic [STAGES-1:0]             c_q, c_d, m_d;
   logic                          ovf_q, zero_q;
   logic                          unused_skew;

   assign en        = ~out_valid | out_ready;
   assign in_ready  = en;
   assign out_valid = vld_pipe[STAGES];

   // Operand bits already consumed and the last stage's skew copy have no reader.
   assign unused_skew = ^{a_q, b_q, m_d};

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] ai, bi, ri;
      logic             ci;
      logic [CHUNK-1:0] s;

      if (k == 0) begin : g_head
         // Subtraction is a + ~b + 1: invert B and inject the +1 as carry-in.
         assign ai = a;
         assign bi = (op == OP_SUB) ? ~b : b;
         assign ci = (op == OP_SUB);
         assign ri = '0;
      end else begin : g_body
         assign ai = a_q[k-1];
         assign bi = b_q[k-1];
         assign ci = c_q[k-1];
         assign ri = r_q[k-1];
      end

      add_chunk #(.CHUNK(CHUNK)) u_chunk (
         .a     (ai[k*CHUNK +: CHUNK]),
         .b     (bi[k*CHUNK +: CHUNK]),
         .cin   (ci),
         .s     (s),
         .cout  (c_d[k]),
         .c_msb (m_d[k])
      );

      assign a_d[k] = ai;
      assign b_d[k] = bi;
      assign r_d[k] = ri | (WIDTH'(s) << (k*CHUNK));
   end

   // Advance valid chain, skew/deskew registers and flags together; hold on stall.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         a_q      <= '0;
         b_q      <= '0;
         r_q      <= '0;
         c_q      <= '0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else if (en) begin
         vld_pipe <= (vld_pipe << 1) | STAGES'(in_valid);
         a_q      <= a_d;
         b_q      <= b_d;
         r_q      <= r_d;
         c_q      <= c_d;
         ovf_q    <= c_d[STAGES-1] ^ m_d[STAGES-1];
         zero_q   <= ~|r_d[STAGES-1];
      end
   end

   assign sum   = r_q[STAGES-1];
   assign c_out = c_q[STAGES-1];
   assign ovf   = ovf_q;
   assign zero  = zero_q;

endmodule

// File: tb/tb_add_sub_pipe.sv
// Directed bench for add_sub_pipe: three instances (8/4, 8/8, 16/4) share
// op/out_ready; results are logged into per-instance queues on transfer.
module tb_add_sub_pipe;

   typedef struct {
      logic [15:0] s;
      logic [2:0]  f;     // {c_out, ovf, zero}
      int          cyc;
   } res_t;

   logic        clk = 1'b0;
   logic        rst_n, iv_p, iv_o, op, out_ready;
   logic [7:0]  a8, b8;
   logic [15:0] a16, b16;

   logic        ir_a, ov_a, c_a, v_a, z_a;
   logic [7:0]  s_a;
   logic        ir_b, ov_b, c_b, v_b, z_b;
   logic [7:0]  s_b;
   logic        ir_c, ov_c, c_c, v_c, z_c;
   logic [15:0] s_c;

   res_t qa[$], qb[$], qc[$];
   int   cyc = 0;
   int   t_issue = 0;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   add_sub_pipe #(.WIDTH(8), .CHUNK(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_p), .in_ready(ir_a), .a(a8), .b(b8), .op(op),
      .out_valid(ov_a), .out_ready(out_ready), .sum(s_a), .c_out(c_a), .ovf(v_a), .zero(z_a));

   add_sub_pipe #(.WIDTH(8), .CHUNK(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_o), .in_ready(ir_b), .a(a8), .b(b8), .op(op),
      .out_valid(ov_b), .out_ready(out_ready), .sum(s_b), .c_out(c_b), .ovf(v_b), .zero(z_b));

   add_sub_pipe #(.WIDTH(16), .CHUNK(4)) dut_c (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_o), .in_ready(ir_c), .a(a16), .b(b16), .op(op),
      .out_valid(ov_c), .out_ready(out_ready), .sum(s_c), .c_out(c_c), .ovf(v_c), .zero(z_c));

   always @(posedge clk) cyc <= cyc + 1;

   // A beat transfers on the next rising edge when valid & ready are seen here.
   always @(negedge clk) begin
      if (ov_a && out_ready) qa.push_back('{s: {8'h00, s_a}, f: {c_a, v_a, z_a}, cyc: cyc});
      if (ov_b && out_ready) qb.push_back('{s: {8'h00, s_b}, f: {c_b, v_b, z_b}, cyc: cyc});
      if (ov_c && out_ready) qc.push_back('{s: s_c, f: {c_c, v_c, z_c}, cyc: cyc});
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One beat into all three instances, then wait (bounded) for every result.
   task automatic run1(input logic o, input logic [7:0] x, input logic [7:0] y,
                       input logic [15:0] xw, input logic [15:0] yw);
      step();
      iv_p = 1'b1; iv_o = 1'b1; op = o;
      a8 = x; b8 = y; a16 = xw; b16 = yw;
      t_issue = cyc;
      step();
      iv_p = 1'b0; iv_o = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (qa.size() > 0 && qb.size() > 0 && qc.size() > 0) break;
         @(negedge clk);
      end
   endtask

   task automatic take(input string tag, input int which, input logic [15:0] es,
                       input logic [2:0] ef, input int lat);
      res_t r;
      int   n;
      r.s = 16'hxxxx; r.f = 3'bxxx; r.cyc = -100;
      n = (which == 0) ? qa.size() : (which == 1) ? qb.size() : qc.size();
      chk({tag, "_cnt"}, n, 1);
      if (n > 0) begin
         case (which)
            0:       r = qa.pop_front();
            1:       r = qb.pop_front();
            default: r = qc.pop_front();
         endcase
      end
      chk({tag, "_res"}, {13'b0, r.s, r.f}, {13'b0, es, ef});
      chk({tag, "_lat"}, r.cyc - t_issue, lat);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; iv_p = 1'b0; iv_o = 1'b0; op = 1'b0; out_ready = 1'b1;
      a8 = '0; b8 = '0; a16 = '0; b16 = '0;

      // 1. reset held 3 cycles
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", ov_a, 0);
      chk("rst_in_ready", ir_a, 1);
      chk("rst_sum", s_a, 0);
      chk("rst_flags", {c_a, v_a, z_a}, 0);
      chk("rst_out_valid_w16", ov_c, 0);
      chk("rst_sum_w16", s_c, 0);

      // 2-4. directed vectors on all three geometries
      run1(1'b0, 8'h03, 8'h01, 16'h0003, 16'h0001);
      take("add_small_a", 0, 16'h0004, 3'b000, 2);
      take("add_small_b", 1, 16'h0004, 3'b000, 1);
      take("add_small_c", 2, 16'h0004, 3'b000, 4);

      run1(1'b0, 8'hFF, 8'h01, 16'hFFFF, 16'h0001);
      take("add_wrap_a", 0, 16'h0000, 3'b101, 2);
      take("add_wrap_b", 1, 16'h0000, 3'b101, 1);
      take("add_wrap_c", 2, 16'h0000, 3'b101, 4);

      run1(1'b0, 8'h7F, 8'h01, 16'h7FFF, 16'h0001);
      take("add_ovf_a", 0, 16'h0080, 3'b010, 2);
      take("add_ovf_b", 1, 16'h0080, 3'b010, 1);
      take("add_ovf_c", 2, 16'h8000, 3'b010, 4);

      run1(1'b1, 8'h80, 8'h01, 16'h8000, 16'h0001);
      take("sub_ovf_a", 0, 16'h007F, 3'b110, 2);
      take("sub_ovf_b", 1, 16'h007F, 3'b110, 1);
      take("sub_ovf_c", 2, 16'h7FFF, 3'b110, 4);

      run1(1'b1, 8'h01, 8'h02, 16'h0001, 16'h0002);
      take("sub_borrow_a", 0, 16'h00FF, 3'b000, 2);
      take("sub_borrow_b", 1, 16'h00FF, 3'b000, 1);
      take("sub_borrow_c", 2, 16'hFFFF, 3'b000, 4);

      // 5. back-to-back beats with a 4-cycle output stall (8/4 instance)
      step();
      iv_p = 1'b1; op = 1'b0; a8 = 8'h10; b8 = 8'h20;
      step();
      a8 = 8'h30; b8 = 8'h40;
      step();
      a8 = 8'h50; b8 = 8'h60; out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("stall_in_ready", ir_a, 0);
         chk("stall_out_valid", ov_a, 1);
         chk("stall_hold", {s_a, c_a, v_a, z_a}, {8'h30, 3'b000});
         step();
      end
      out_ready = 1'b1;
      step();
      iv_p = 1'b0;
      repeat (6) @(negedge clk);
      chk("b2b_count", qa.size(), 3);
      if (qa.size() == 3) begin
         chk("b2b_0", {qa[0].s, qa[0].f}, {16'h0030, 3'b000});
         chk("b2b_1", {qa[1].s, qa[1].f}, {16'h0070, 3'b000});
         chk("b2b_2", {qa[2].s, qa[2].f}, {16'h00B0, 3'b010});
      end
      qa.delete();

      // 6. reset with two beats in flight, output held off
      step();
      iv_p = 1'b1; a8 = 8'h11; b8 = 8'h22; out_ready = 1'b0;
      step();
      a8 = 8'h01; b8 = 8'h01;
      step();
      iv_p = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      chk("flight_out_valid", ov_a, 1);
      step();
      rst_n = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk("midrst_out_valid", ov_a, 0);
      chk("midrst_sum", s_a, 0);
      repeat (6) @(negedge clk);
      chk("midrst_no_output", qa.size(), 0);
      chk("midrst_ready", ir_a, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
